// File: rtl/reg_cmd_ctrl_pkg.sv
// reg_cmd_ctrl_pkg: opcodes, FSM state type and register-file geometry shared with the register file
package reg_cmd_ctrl_pkg;
  localparam int RF_WIDTH = 8;
  localparam int RF_ADDR_W = 4;
  localparam logic [7:0] OP_WRITE = 8'hAA;
  localparam logic [7:0] OP_READ = 8'hBB;
  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
  } state_t;
endpackage

// File: rtl/reg_cmd_ctrl_if.sv
// reg_cmd_ctrl_if: UART RX/TX and register-file signals around the command controller
interface reg_cmd_ctrl_if import reg_cmd_ctrl_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
);
  logic [WIDTH-1:0] RX_P_DATA;
  logic RX_D_VLD;
  logic [WIDTH-1:0] RdData;
  logic RdData_Valid;
  logic TX_BUSY;
  logic WrEn;
  logic RdEn;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] TX_P_DATA;
  logic TX_D_VLD;
  logic CMD_ERR;
  modport master (
    input RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    input WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: decodes UART write/read frames into register-file accesses and returns read bytes to UART TX
module reg_cmd_ctrl import reg_cmd_ctrl_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH = 16,
  parameter int RD_TIMEOUT = 8
) (
  input logic CLK,
  input logic RST,
  reg_cmd_ctrl_if.master bus
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_wr_en, w_wr_en, r_rd_en, w_rd_en, r_tx_vld, w_tx_vld, r_err, w_err;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [WIDTH-1:0] r_wr_data, w_wr_data, r_tx_data, w_tx_data;
  logic w_vld, w_addr_ok;
  assign w_vld = bus.RX_D_VLD;
  assign w_addr_ok = 32'(bus.RX_P_DATA) < DEPTH;
  always_ff @(posedge CLK)
    r_state <= RST ? IDLE : w_state;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    w_err = 1'b0;
    w_addr = r_addr;
    w_wr_data = r_wr_data;
    w_tx_data = r_tx_data;
    w_tx_vld = r_tx_vld;
    case (r_state)
      IDLE: if (w_vld) begin
        w_state = (bus.RX_P_DATA == OP_WRITE) ? WR_ADDR : (bus.RX_P_DATA == OP_READ) ? RD_ADDR : IDLE;
        w_err = (bus.RX_P_DATA != OP_WRITE) && (bus.RX_P_DATA != OP_READ);
      end
      WR_ADDR, RD_ADDR: if (w_vld) begin
        w_err = !w_addr_ok;
        w_addr = w_addr_ok ? bus.RX_P_DATA[ADDR_W-1:0] : r_addr;
        w_rd_en = w_addr_ok && (r_state == RD_ADDR);
        w_state = !w_addr_ok ? IDLE : (r_state == WR_ADDR) ? WR_DATA : RD_EXEC;
      end
      WR_DATA: if (w_vld) begin
        w_wr_data = bus.RX_P_DATA;
        w_wr_en = 1'b1;
        w_state = WR_EXEC;
      end
      WR_EXEC: begin
        w_err = w_vld;
        w_state = IDLE;
      end
      RD_EXEC: begin
        w_err = w_vld;
        w_cnt = '0;
        w_state = RD_WAIT;
      end
      RD_WAIT: begin
        w_err = w_vld;
        if (bus.RdData_Valid) begin
          w_tx_data = bus.RdData;
          w_tx_vld = 1'b1;
          w_state = TX_SEND;
        end else if (r_cnt >= CW'(RD_TIMEOUT - 1)) begin
          w_err = 1'b1;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      TX_SEND: begin
        w_err = w_vld;
        w_tx_vld = bus.TX_BUSY;
        w_state = bus.TX_BUSY ? TX_SEND : IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_tx_vld <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_wr_data <= '0;
      r_tx_data <= '0;
    end else begin
      r_cnt <= w_cnt;
      r_wr_en <= w_wr_en;
      r_rd_en <= w_rd_en;
      r_tx_vld <= w_tx_vld;
      r_err <= w_err;
      r_addr <= w_addr;
      r_wr_data <= w_wr_data;
      r_tx_data <= w_tx_data;
    end
  end
  assign bus.WrEn = r_wr_en;
  assign bus.RdEn = r_rd_en;
  assign bus.Address = r_addr;
  assign bus.WrData = r_wr_data;
  assign bus.TX_P_DATA = r_tx_data;
  assign bus.TX_D_VLD = r_tx_vld;
  assign bus.CMD_ERR = r_err;
endmodule
